key_select_encoder: RTL

Upstream front end for the filter/frequency select encoder. It takes the four raw active-low board pushbuttons and debounces each one. It then steps an internal selection state (mode plus per-mode index) and drives the held 4-bit `buttons` code that the select encoder consumes on clk_48. The code is 0-7 for frequency index, 8-11 for lowpass index and 12-15 for highpass index. It is held constant between presses, so the downstream selects change only on a debounced press.

---
 rtl/key_select_pkg.sv | 40 ++++
 rtl/key_debounce.sv | 47 ++++
 rtl/key_select_encoder.sv | 100 ++++++++++
 3 files changed

// File: rtl/key_select_pkg.sv
// Shared types and constants for the pushbutton front end of the select encoder.
package key_select_pkg;

  typedef enum logic [1:0] {
    MODE_FREQ = 2'd0,
    MODE_LP   = 2'd1,
    MODE_HP   = 2'd2
  } mode_t;

  localparam logic [3:0] LP_BASE = 4'd8;
  localparam logic [3:0] HP_BASE = 4'd12;

  localparam logic [2:0] FREQ_DEF = 3'd4;
  localparam logic [1:0] LP_DEF   = 2'd1;
  localparam logic [1:0] HP_DEF   = 2'd3;

  localparam int KEY_NEXT = 0;
  localparam int KEY_PREV = 1;
  localparam int KEY_MODE = 2;
  localparam int KEY_DEF  = 3;

  localparam int NUM_KEYS = 4;

  // Downstream code: the active mode selects which stored index is sent.
  function automatic logic [3:0] encode_buttons(
    input mode_t      m,
    input logic [2:0] freq_idx,
    input logic [1:0] lp_idx,
    input logic [1:0] hp_idx
  );
    logic [3:0] code;
    case (m)
      MODE_LP: code = LP_BASE + {2'b00, lp_idx};
      MODE_HP: code = HP_BASE + {2'b00, hp_idx};
      default: code = {1'b0, freq_idx};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton channel: 2-flop synchronizer, debounce counter, and a
// single-cycle pulse when the debounced level falls (press).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 960,
  parameter int CNT_W           = 16
) (
  input  logic clk_48,
  input  logic reset_n,
  input  logic key_n,
  output logic press_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic             press_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      press_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // Stable long enough: accept the new level; only a fall is a press.
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
        press_reg <= ~sync2_reg;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign press_evt = press_reg;

endmodule

// File: rtl/key_select_encoder.sv
// Debounces four board keys and steps mode/index state to drive the held
// 4-bit select code for the downstream encoder.
module key_select_encoder
  import key_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 960,
  parameter int CNT_W           = 16
) (
  input  logic       clk_48,
  input  logic       reset_n,
  input  logic [3:0] key_n,
  output logic [3:0] buttons,
  output logic [1:0] mode,
  output logic       key_event
);

  logic [NUM_KEYS-1:0] press_evt;

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_debounce (
        .clk_48   (clk_48),
        .reset_n  (reset_n),
        .key_n    (key_n[gi]),
        .press_evt(press_evt[gi])
      );
    end
  endgenerate

  mode_t      mode_reg,     mode_next;
  logic [2:0] freq_idx_reg, freq_idx_next;
  logic [1:0] lp_idx_reg,   lp_idx_next;
  logic [1:0] hp_idx_reg,   hp_idx_next;
  logic [3:0] buttons_reg;
  logic       event_reg,    event_next;

  // Highest-priority press wins; simultaneous lower presses are dropped.
  // Index wraps fall out of the natural register widths.
  always_comb begin
    mode_next     = mode_reg;
    freq_idx_next = freq_idx_reg;
    lp_idx_next   = lp_idx_reg;
    hp_idx_next   = hp_idx_reg;
    event_next    = 1'b0;
    if (press_evt[KEY_DEF]) begin
      mode_next     = MODE_FREQ;
      freq_idx_next = FREQ_DEF;
      lp_idx_next   = LP_DEF;
      hp_idx_next   = HP_DEF;
      event_next    = 1'b1;
    end else if (press_evt[KEY_MODE]) begin
      case (mode_reg)
        MODE_FREQ: mode_next = MODE_LP;
        MODE_LP:   mode_next = MODE_HP;
        default:   mode_next = MODE_FREQ;
      endcase
      event_next = 1'b1;
    end else if (press_evt[KEY_PREV]) begin
      case (mode_reg)
        MODE_LP: lp_idx_next   = lp_idx_reg - 2'd1;
        MODE_HP: hp_idx_next   = hp_idx_reg - 2'd1;
        default: freq_idx_next = freq_idx_reg - 3'd1;
      endcase
      event_next = 1'b1;
    end else if (press_evt[KEY_NEXT]) begin
      case (mode_reg)
        MODE_LP: lp_idx_next   = lp_idx_reg + 2'd1;
        MODE_HP: hp_idx_next   = hp_idx_reg + 2'd1;
        default: freq_idx_next = freq_idx_reg + 3'd1;
      endcase
      event_next = 1'b1;
    end
  end

  always_ff @(posedge clk_48 or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg     <= MODE_FREQ;
      freq_idx_reg <= FREQ_DEF;
      lp_idx_reg   <= LP_DEF;
      hp_idx_reg   <= HP_DEF;
      buttons_reg  <= {1'b0, FREQ_DEF};
      event_reg    <= 1'b0;
    end else begin
      mode_reg     <= mode_next;
      freq_idx_reg <= freq_idx_next;
      lp_idx_reg   <= lp_idx_next;
      hp_idx_reg   <= hp_idx_next;
      buttons_reg  <= encode_buttons(mode_next, freq_idx_next, lp_idx_next, hp_idx_next);
      event_reg    <= event_next;
    end
  end

  assign buttons   = buttons_reg;
  assign mode      = mode_reg;
  assign key_event = event_reg;

endmodule
